seg_bus_arbiter: RTL

SEG_BUS_ARBITER -- requirements
Module: seg_bus_arbiter

---
 rtl/seg_bus_arbiter.sv | 70 +++++++
 1 files changed

// File: rtl/seg_bus_arbiter.sv
// seg_bus_arbiter: two-requester round-robin arbiter for a shared 7-bit segment bus
module seg_bus_arbiter #(
    parameter int HOLD_MAX = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req1,
    input  logic       req2,
    input  logic       done1,
    input  logic       done2,
    input  logic [6:0] data1,
    input  logic [6:0] data2,
    output logic       gnt1,
    output logic       gnt2,
    output logic       sel,
    output logic [6:0] bus_out,
    output logic       bus_valid
);
    typedef enum logic [1:0] {IDLE, OWN1, OWN2} state_t;
    localparam logic [3:0] HM = 4'(HOLD_MAX);
    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       last2_q, last2_d, sel_q, sel_d, rel;
    logic [6:0] bus_q;
    logic       valid_q;
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last2_d = last2_q;
        rel     = state_q == OWN1 ? (done1 || !req1 || cnt_q == HM)
                                  : (done2 || !req2 || cnt_q == HM);
        if (state_q == IDLE) begin
            // on a tie, last2_q high means requester 1 is due
            if (req1 && (!req2 || last2_q)) state_d = OWN1;
            else if (req2) state_d = OWN2;
            if (state_d != IDLE) begin
                cnt_d   = 4'd1;
                last2_d = state_d == OWN2;
            end
        end else if (rel) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + {3'b000, cnt_q != 4'hF};
        end
        sel_d = state_d == OWN1 ? 1'b0 : state_d == OWN2 ? 1'b1 : sel_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            last2_q <= 1'b1;
            sel_q   <= 1'b0;
            bus_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last2_q <= last2_d;
            sel_q   <= sel_d;
            bus_q   <= state_q == IDLE ? 7'd0 : (sel_q ? data2 : data1);
            valid_q <= state_q != IDLE;
        end
    end
    assign gnt1      = state_q == OWN1;
    assign gnt2      = state_q == OWN2;
    assign sel       = sel_q;
    assign bus_out   = bus_q;
    assign bus_valid = valid_q;
endmodule
